// File: rtl/fibonacci_decoder_pkg.sv
// Shared constants and state encoding for the serial Fibonacci decoder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: default widths, FSM state encoding, Fibonacci seed weights and
// the index of the highest digit whose weight still fits in the binary result.
package fibonacci_decoder_pkg;

    localparam int FIB_W_DEF = 128;
    localparam int BIN_W_DEF = 64;

    // Weights of digit 0 and digit 1: F(2) = 1, F(3) = 2.
    localparam int unsigned F2_SEED = 1;
    localparam int unsigned F3_SEED = 2;

    // Digit 91 carries F(93), the largest Fibonacci number below 2^64.
    localparam int F93_IDX = 91;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fibonacci_decoder_if.sv
// Request/result bundle between a Fibonacci decoder and its client.
// Latency: n/a (wires only).
// Backpressure: none; the client must watch busy/decode_done before a new request.
// master: drives en_decode, fibonacci_in; slave: drives binary_out, decode_done,
// busy, overflow, non_canonical.
interface fibonacci_decoder_if
    import fibonacci_decoder_pkg::*;
#(
    parameter int FIB_W = FIB_W_DEF,
    parameter int BIN_W = BIN_W_DEF
);

    logic             en_decode;
    logic [FIB_W-1:0] fibonacci_in;
    logic [BIN_W-1:0] binary_out;
    logic             decode_done;
    logic             busy;
    logic             overflow;
    logic             non_canonical;

    modport master (
        output en_decode,
        output fibonacci_in,
        input  binary_out,
        input  decode_done,
        input  busy,
        input  overflow,
        input  non_canonical
    );

    modport slave (
        input  en_decode,
        input  fibonacci_in,
        output binary_out,
        output decode_done,
        output busy,
        output overflow,
        output non_canonical
    );

endinterface

// File: rtl/fibonacci_decoder_weight_gen.sv
// Fibonacci weight sequencer: presents the weight of the current digit, modulo 2^BIN_W.
// Latency: weight for the next digit one clock after step_i; seeds one clock after init_i.
// Backpressure: none; advances exactly when step_i is high.
// Ports: clk, rst (sync, active-high), init_i (load F2/F3), step_i (advance),
//        wa_o (current weight, truncated), wbig_o (true current weight >= 2^BIN_W).
module fibonacci_decoder_weight_gen
    import fibonacci_decoder_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_i,
    input  logic             step_i,
    output logic [BIN_W-1:0] wa_o,
    output logic             wbig_o
);

    logic [BIN_W-1:0] wa_q, wa_d;
    logic [BIN_W-1:0] wb_q, wb_d;
    logic             wa_big_q, wa_big_d;
    logic             wb_big_q, wb_big_d;
    logic [BIN_W:0]   sum;

    assign sum = {1'b0, wa_q} + {1'b0, wb_q};

    // Each weight carries its own "true value has left the range" flag. Because the
    // sequence is increasing, the flag on the sum is the OR of both inputs' flags and
    // the truncation carry, and it then rolls forward from wb into wa.
    always_comb begin
        wa_d     = wa_q;
        wb_d     = wb_q;
        wa_big_d = wa_big_q;
        wb_big_d = wb_big_q;
        if (init_i) begin
            wa_d     = BIN_W'(F2_SEED);
            wb_d     = BIN_W'(F3_SEED);
            wa_big_d = 1'b0;
            wb_big_d = 1'b0;
        end else if (step_i) begin
            wa_d     = wb_q;
            wb_d     = sum[BIN_W-1:0];
            wa_big_d = wb_big_q;
            wb_big_d = wa_big_q | wb_big_q | sum[BIN_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wa_q     <= '0;
            wb_q     <= '0;
            wa_big_q <= 1'b0;
            wb_big_q <= 1'b0;
        end else begin
            wa_q     <= wa_d;
            wb_q     <= wb_d;
            wa_big_q <= wa_big_d;
            wb_big_q <= wb_big_d;
        end
    end

    assign wa_o   = wa_q;
    assign wbig_o = wa_big_q;

endmodule

// File: rtl/fibonacci_decoder.sv
// Serial Fibonacci-to-binary decoder (non-canonical words accepted), one digit per clock.
// Latency: decode_done at accept edge + highest set digit + 2 (zero word +2, max +FIB_W+1).
// Backpressure: none; en_decode is ignored while busy and in the DONE cycle, never queued.
// Ports: clk, rst (sync, active-high); dec (slave): en_decode, fibonacci_in in;
//        binary_out, decode_done, busy, overflow, non_canonical out.
// Build option: define FIB_DEC_CANON_CHECK_EN to flag words with adjacent 1 digits;
//               otherwise non_canonical is tied low and the check is not built.
module fibonacci_decoder
    import fibonacci_decoder_pkg::*;
#(
    parameter int FIB_W = FIB_W_DEF,
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    fibonacci_decoder_if.slave dec
);

    state_t           state_q, state_d;
    logic [FIB_W-1:0] sr_q, sr_d;
    logic [FIB_W-1:0] sr_shift;
    logic [BIN_W-1:0] acc_q, acc_d;
    logic [BIN_W:0]   acc_sum;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             ovf_out_q, ovf_out_d;
    logic             wg_init;
    logic             wg_step;
    logic [BIN_W-1:0] wa;
    logic             wbig;
`ifdef FIB_DEC_CANON_CHECK_EN
    logic             nc_q, nc_d;
    logic             nc_out_q, nc_out_d;
`endif

    fibonacci_decoder_weight_gen #(
        .BIN_W (BIN_W)
    ) u_weight_gen (
        .clk    (clk),
        .rst    (rst),
        .init_i (wg_init),
        .step_i (wg_step),
        .wa_o   (wa),
        .wbig_o (wbig)
    );

    assign sr_shift = sr_q >> 1;
    assign acc_sum  = {1'b0, acc_q} + {1'b0, wa};

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bin_d     = bin_q;
        ovf_out_d = ovf_out_q;
        wg_init   = 1'b0;
        wg_step   = 1'b0;
`ifdef FIB_DEC_CANON_CHECK_EN
        nc_d      = nc_q;
        nc_out_d  = nc_out_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (dec.en_decode) begin
                    sr_d    = dec.fibonacci_in;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    wg_init = 1'b1;
`ifdef FIB_DEC_CANON_CHECK_EN
                    nc_d    = 1'b0;
`endif
                    // A zero word also passes through one ACCUM cycle, so its done
                    // pulse lands two edges after accept just like a bit-0-only word.
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                wg_step = 1'b1;
                if (sr_q[0]) begin
                    acc_d = acc_sum[BIN_W-1:0];
                    // Either the running sum wrapped, or the weight itself was
                    // already out of range before truncation.
                    if (acc_sum[BIN_W] || wbig) begin
                        ovf_d = 1'b1;
                    end
                end
`ifdef FIB_DEC_CANON_CHECK_EN
                if (sr_q[0] && sr_q[1]) begin
                    nc_d = 1'b1;
                end
`endif
                sr_d = sr_shift;
                if (sr_shift == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bin_d     = acc_q;
                ovf_out_d = ovf_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
`ifdef FIB_DEC_CANON_CHECK_EN
                nc_out_d  = nc_q;
`endif
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bin_q     <= '0;
            ovf_out_q <= 1'b0;
`ifdef FIB_DEC_CANON_CHECK_EN
            nc_q      <= 1'b0;
            nc_out_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bin_q     <= bin_d;
            ovf_out_q <= ovf_out_d;
`ifdef FIB_DEC_CANON_CHECK_EN
            nc_q      <= nc_d;
            nc_out_q  <= nc_out_d;
`endif
        end
    end

    assign dec.binary_out  = bin_q;
    assign dec.decode_done = done_q;
    assign dec.busy        = busy_q;
    assign dec.overflow    = ovf_out_q;
`ifdef FIB_DEC_CANON_CHECK_EN
    assign dec.non_canonical = nc_out_q;
`else
    assign dec.non_canonical = 1'b0;
`endif

endmodule

// File: tb/tb_fibonacci_decoder.sv
// Self-checking bench for fibonacci_decoder: scoreboard of expected results and done cycles.
// Latency: n/a.
// Backpressure: n/a.
module tb_fibonacci_decoder;
    import fibonacci_decoder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    int   vec_id = 0;

    typedef struct {
        int          id;
        logic [63:0] val;
        logic        ovf;
        logic        nc;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fibonacci_decoder_if dec ();

    fibonacci_decoder dut (
        .clk (clk),
        .rst (rst),
        .dec (dec)
    );

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // True (unbounded) value of a Fibonacci word; 128 bits hold any 128-digit sum.
    function automatic logic [127:0] fib_sum(input logic [127:0] w);
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] s;
        logic [127:0] t;
        a = 128'd1;
        b = 128'd2;
        s = '0;
        for (int i = 0; i < 128; i++) begin
            if (w[i]) s = s + a;
            t = a + b;
            a = b;
            b = t;
        end
        return s;
    endfunction

    function automatic logic nc_model(input logic [127:0] w);
`ifdef FIB_DEC_CANON_CHECK_EN
        return |(w & (w >> 1));
`else
        return (w == 128'h0) && (w != 128'h0);
`endif
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (dec.decode_done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("v%0d_value", e.id), dec.binary_out, e.val);
                chk($sformatf("v%0d_overflow", e.id), dec.overflow, e.ovf);
                chk($sformatf("v%0d_non_canonical", e.id), dec.non_canonical, e.nc);
                chk($sformatf("v%0d_done_cycle", e.id), cyc, e.cyc);
            end
        end
    end

    // Called at negedge+1 with the DUT idle. hold keeps en_decode high for the whole
    // decode; toggle inverts fibonacci_in right after the accept.
    task automatic send(input logic [127:0] w, input bit hold, input bit toggle);
        exp_t         e;
        logic [127:0] s;
        int           h;
        s = fib_sum(w);
        h = 0;
        for (int i = 0; i < 128; i++) if (w[i]) h = i;
        e.id  = vec_id;
        e.val = s[63:0];
        e.ovf = |s[127:64];
        e.nc  = nc_model(w);
        e.cyc = cyc + 1 + h + 2;
        vec_id++;
        sb.push_back(e);
        dec.en_decode    = 1'b1;
        dec.fibonacci_in = w;
        @(negedge clk); #1;
        chk($sformatf("v%0d_busy", e.id), dec.busy, 1'b1);
        if (!hold) dec.en_decode = 1'b0;
        if (toggle) dec.fibonacci_in = ~w;
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        chk($sformatf("v%0d_timeout", e.id), sb.size(), 0);
        sb.delete();
        dec.en_decode = 1'b0;
        @(negedge clk); #1;
        chk($sformatf("v%0d_idle_busy", e.id), dec.busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] w;
        rst              = 1'b1;
        dec.en_decode    = 1'b0;
        dec.fibonacci_in = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_binary_out", dec.binary_out, 64'd0);
        chk("rst_decode_done", dec.decode_done, 1'b0);
        chk("rst_busy", dec.busy, 1'b0);
        chk("rst_overflow", dec.overflow, 1'b0);
        chk("rst_non_canonical", dec.non_canonical, 1'b0);
        rst = 1'b0;
        @(negedge clk); #1;

        send(128'h1, 1'b0, 1'b0);
        send(128'b1010, 1'b0, 1'b0);
        send(128'b11, 1'b0, 1'b0);
        send(128'h0, 1'b0, 1'b0);
        w = '0; w[F93_IDX] = 1'b1;
        send(w, 1'b0, 1'b0);
        chk("bit91_const", dec.binary_out, 64'd12200160415121876738);
        w = '0; w[F93_IDX + 1] = 1'b1;
        send(w, 1'b0, 1'b0);
        w = '0; w[127] = 1'b1;
        send(w, 1'b0, 1'b0);
        send(128'b10101, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        send(128'h5_2492_0049, 1'b0, 1'b1);
        send({96'h0, 32'($urandom)}, 1'b0, 1'b0);
        send({32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)}, 1'b0, 1'b0);
        send({128{1'b1}}, 1'b0, 1'b0);

        // Abort an in-flight decode: rst sampled at accept + 3 edges.
        dec.en_decode    = 1'b1;
        dec.fibonacci_in = 128'hFF;
        @(negedge clk); #1;
        dec.en_decode = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("abort_binary_out", dec.binary_out, 64'd0);
        chk("abort_decode_done", dec.decode_done, 1'b0);
        chk("abort_busy", dec.busy, 1'b0);
        chk("abort_overflow", dec.overflow, 1'b0);
        chk("abort_non_canonical", dec.non_canonical, 1'b0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        send(128'b1010, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
